// File: rtl/spi_xfer_if.sv
// spi_xfer_if: SPI-side FIFO port bundle between spi_xfer_ctrl (master) and the TX/RX FIFOs (slave).
interface spi_xfer_if #(parameter int DATA_W = 8);
  logic              tx_empty_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_r_en_o;
  logic              rx_full_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_w_en_o;
  modport master (input tx_empty_i, tx_data_i, rx_full_i, output tx_r_en_o, rx_data_o, rx_w_en_o);
  modport slave (output tx_empty_i, tx_data_i, rx_full_i, input tx_r_en_o, rx_data_o, rx_w_en_o);
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI mode-0 MSB-first transfer sequencer between TX/RX FIFOs and the SPI pins.
// Define SPI_LOOPBACK_EN to let lpbk_i feed mosi_o back into the shifter.
module spi_xfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] clk_div_i,
  spi_xfer_if.master       fifo,
  output logic             sclk_o,
  output logic             mosi_o,
  input  logic             miso_i,
  output logic             cs_n_o,
  output logic             busy_o,
  output logic             rx_ovf_o,
  input  logic             ovf_clr_i,
  input  logic             lpbk_i
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT = 3'd2, SHIFT = 3'd3, DONE = 3'd4;
  localparam int BW = $clog2(DATA_W);
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, ovf_q, ovf_d;
  logic              sin, tick, more;
`ifdef SPI_LOOPBACK_EN
  assign sin = lpbk_i ? mosi_q : miso_i;
`else
  logic unused_lpbk;
  assign unused_lpbk = lpbk_i;
  assign sin = miso_i;
`endif
  assign tick = cnt_q == '0;
  assign more = en_i && !fifo.tx_empty_i;
  assign fifo.tx_r_en_o = state_q == LOAD;
  assign fifo.rx_w_en_o = state_q == DONE && !fifo.rx_full_i;
  assign fifo.rx_data_o = rx_q;
  assign sclk_o   = sclk_q;
  assign mosi_o   = mosi_q;
  assign cs_n_o   = cs_n_q;
  assign busy_o   = state_q != IDLE;
  assign rx_ovf_o = ovf_q;
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    ovf_d   = (state_q == DONE && fifo.rx_full_i) || (ovf_q && !ovf_clr_i);
    case (state_q)
      IDLE: state_d = more ? LOAD : IDLE;
      LOAD: state_d = WAIT;
      WAIT: begin
        tx_d    = fifo.tx_data_i;
        div_d   = clk_div_i;
        cnt_d   = clk_div_i;
        bit_d   = '0;
        mosi_d  = fifo.tx_data_i[DATA_W-1];
        cs_n_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = tick ? div_q : cnt_q - 1'b1;
        if (tick) begin
          sclk_d = !sclk_q;
          // low->high samples, high->low advances to the next bit
          if (!sclk_q) rx_d = {rx_q[DATA_W-2:0], sin};
          else begin
            tx_d    = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_q[DATA_W-2];
            bit_d   = bit_q + 1'b1;
            state_d = bit_q == BW'(DATA_W-1) ? DONE : SHIFT;
          end
        end
      end
      DONE: begin
        state_d = more ? LOAD : IDLE;
        cs_n_d  = !more;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench with FIFO/SPI-slave models for spi_xfer_ctrl.
module tb_spi_xfer_ctrl;
`ifdef SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  typedef struct {logic [7:0] tx; logic [7:0] rx; bit drop;} exp_t;
  typedef struct {logic [7:0] miso; bit drop;} sl_t;
  logic clk = 0, rst_n = 0, en_i = 0, miso_i = 0, ovf_clr_i = 0, lpbk_i = 0;
  logic [7:0] clk_div_i = 0;
  logic sclk_o, mosi_o, cs_n_o, busy_o, rx_ovf_o;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] txq[$];
  sl_t sq[$];
  exp_t expq[$];
  spi_xfer_if #(.DATA_W(8)) fifo_if();
  spi_xfer_ctrl #(.DATA_W(8), .DIV_W(8)) dut (
    .clk_i(clk), .rst_n(rst_n), .en_i(en_i), .clk_div_i(clk_div_i), .fifo(fifo_if),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i), .cs_n_o(cs_n_o), .busy_o(busy_o),
    .rx_ovf_o(rx_ovf_o), .ovf_clr_i(ovf_clr_i), .lpbk_i(lpbk_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic push(input logic [7:0] tx, input logic [7:0] mi, input bit drop);
    exp_t e;
    sl_t s;
    e.tx = tx;
    e.rx = (LB && lpbk_i) ? tx : mi;
    e.drop = drop;
    s.miso = mi;
    s.drop = drop;
    txq.push_back(tx);
    sq.push_back(s);
    expq.push_back(e);
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge clk);
    while ((busy_o || txq.size() != 0 || expq.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < lim), 1);
  endtask
  // TX FIFO with registered read, and a mode-0 slave that shifts out on SCLK falls
  logic [7:0] cur = 0;
  int k = 0;
  logic sp = 0;
  initial begin
    fifo_if.tx_empty_i = 1;
    fifo_if.tx_data_i = 0;
    fifo_if.rx_full_i = 0;
  end
  always @(negedge clk) begin
    sl_t s;
    if (fifo_if.tx_r_en_o && txq.size() > 0) begin
      fifo_if.tx_data_i = txq.pop_front();
      s = sq.pop_front();
      cur = s.miso;
      fifo_if.rx_full_i = s.drop;
      k = 0;
      miso_i = cur[7];
    end else if (sp && !sclk_o) begin
      k++;
      if (k < 8) miso_i = cur[7-k];
    end
    sp = sclk_o;
    fifo_if.tx_empty_i = txq.size() == 0;
  end
  // monitor: checks every frame end, MOSI bits, SCLK period and enable exclusivity
  logic psclk = 0, chk_ovf = 0;
  int nfall = 0, ridx = 0, last_rise = 0;
  logic [7:0] macc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      psclk = 0; chk_ovf = 0; nfall = 0; ridx = 0; macc = 0;
    end else begin
      chk("excl", 32'(fifo_if.tx_r_en_o & fifo_if.rx_w_en_o), 0);
      if (chk_ovf) begin
        chk("ovf_set", 32'(rx_ovf_o), 1);
        chk_ovf = 0;
      end
      if (!psclk && sclk_o) begin
        if (ridx != 0) chk("sclk_period", 32'(cyc - last_rise), 32'(2 * (clk_div_i + 1)));
        last_rise = cyc;
        ridx = (ridx + 1) % 8;
        macc = {macc[6:0], mosi_o};
      end
      if (psclk && !sclk_o) nfall++;
      if (psclk && !sclk_o && nfall % 8 == 0) begin
        if (expq.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          e = expq.pop_front();
          chk("mosi_byte", 32'(macc), 32'(e.tx));
          chk("cs_low_done", 32'(cs_n_o), 0);
          if (e.drop) begin
            chk("wen_drop", 32'(fifo_if.rx_w_en_o), 0);
            chk_ovf = 1;
          end else begin
            chk("wen", 32'(fifo_if.rx_w_en_o), 1);
            chk("rx_data", 32'(fifo_if.rx_data_o), 32'(e.rx));
          end
        end
      end else chk("wen_idle", 32'(fifo_if.rx_w_en_o), 0);
      psclk = sclk_o;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, t0, cr, fl;
    logic pc;
    en_i = 1;
    push(8'hA5, 8'h3C, 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_cs", 32'(cs_n_o), 1);
      chk("rst_sclk", 32'(sclk_o), 0);
      chk("rst_ren", 32'(fifo_if.tx_r_en_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
    end
    chk("rst_misc", {fifo_if.rx_data_o, 5'(0), mosi_o, rx_ovf_o, fifo_if.rx_w_en_o}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("load_after_rst", 32'(fifo_if.tx_r_en_o), 1);
    t0 = cyc;
    n = 0;
    while (busy_o && n < 100) begin @(negedge clk); n++; end
    chk("latency19", 32'(cyc - t0), 19);
    wait_idle(200);
    // two back-to-back bytes, divider 3
    clk_div_i = 3;
    push(8'h01, 8'h96, 0);
    push(8'hFF, 8'h5E, 0);
    cr = 0; n = 0; pc = cs_n_o;
    @(negedge clk);
    while ((busy_o || txq.size() != 0) && n < 400) begin
      if (!pc && cs_n_o) cr++;
      pc = cs_n_o;
      @(negedge clk);
      n++;
    end
    if (!pc && cs_n_o) cr++;
    chk("cs_rises", 32'(cr), 1);
    wait_idle(200);
    // overflow, then set-vs-clear collision, then plain clear
    clk_div_i = 0;
    push(8'h11, 8'h22, 1);
    wait_idle(200);
    chk("ovf_sticky", 32'(rx_ovf_o), 1);
    push(8'h33, 8'h44, 1);
    fl = 0; n = 0; pc = sclk_o;
    while (fl < 8 && n < 200) begin
      @(negedge clk);
      if (pc && !sclk_o) fl++;
      pc = sclk_o;
      n++;
    end
    ovf_clr_i = 1;
    @(negedge clk);
    ovf_clr_i = 0;
    chk("ovf_set_wins", 32'(rx_ovf_o), 1);
    wait_idle(200);
    ovf_clr_i = 1;
    @(negedge clk);
    ovf_clr_i = 0;
    chk("ovf_clear", 32'(rx_ovf_o), 0);
    // en_i dropped mid-burst
    clk_div_i = 1;
    push(8'hC3, 8'h96, 0);
    push(8'h7E, 8'h81, 0);
    cr = 0; n = 0; pc = sclk_o;
    while (cr < 4 && n < 200) begin
      @(negedge clk);
      if (!pc && sclk_o) cr++;
      pc = sclk_o;
      n++;
    end
    en_i = 0;
    n = 0;
    while (busy_o && n < 200) begin @(negedge clk); n++; end
    chk("en_drop_left", 32'(txq.size()), 1);
    chk("en_drop_exp", 32'(expq.size()), 1);
    chk("en_drop_cs", 32'(cs_n_o), 1);
    txq.delete(); sq.delete(); expq.delete();
    repeat (2) @(negedge clk);
    en_i = 1;
    // loopback
    lpbk_i = 1;
    push(8'h5A, 8'h00, 0);
    wait_idle(200);
    lpbk_i = 0;
    // randomized bursts
    for (int r = 0; r < 10; r++) begin
      clk_div_i = 8'($urandom_range(0, 3));
      lpbk_i = 1'($urandom_range(0, 1));
      for (int b = 0; b < int'($urandom_range(1, 3)); b++)
        push(8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      wait_idle(800);
      ovf_clr_i = 1;
      @(negedge clk);
      ovf_clr_i = 0;
    end
    lpbk_i = 0;
    // reset in the middle of a byte
    clk_div_i = 2;
    push(8'hE7, 8'h18, 0);
    repeat (20) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_cs", 32'(cs_n_o), 1);
    chk("mid_rst_sclk", 32'(sclk_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_en", {30'(0), fifo_if.tx_r_en_o, fifo_if.rx_w_en_o}, 0);
    chk("mid_rst_data", {fifo_if.rx_data_o, 7'(0), mosi_o}, 0);
    txq.delete(); sq.delete(); expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(busy_o), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
